// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcodes, NOP encoding and immediate formats
package rv32i_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: combinational field split, immediate extraction and legality check
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] insn,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        legal,
  output logic        is_jal
);
  imm_fmt_e fmt;
  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign funct3 = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign funct7 = insn[31:25];
  assign is_jal = opcode == OP_JAL;
  always_comb begin
    fmt   = IMM_R;
    legal = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC:                               fmt = IMM_U;
      OP_JAL:                                         fmt = IMM_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:  fmt = IMM_I;
      OP_BRANCH:                                      fmt = IMM_B;
      OP_STORE:                                       fmt = IMM_S;
      OP_REG:                                         fmt = IMM_R;
      default:                                        legal = 1'b0;
    endcase
  end
  assign imm = fmt == IMM_I ? {{20{insn[31]}}, insn[31:20]} :
               fmt == IMM_S ? {{20{insn[31]}}, insn[31:25], insn[11:7]} :
               fmt == IMM_B ? {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0} :
               fmt == IMM_U ? {insn[31:12], 12'h000} :
               fmt == IMM_J ? {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0} :
                              32'h0;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: RV32I fetch/decode front end with local JAL resolution and sticky exception
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        exception,
  output logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_insn,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [31:0] id_imm
);
  import rv32i_pkg::*;
  logic [31:0] if_pc;
  logic [31:0] target;
  logic        legal, is_jal, fault, redirect;
  assign imem_addr = if_pc;
  assign id_insn   = imem_valid ? imem_rdata : NOP;
  rv32i_decoder u_dec (
    .insn   (id_insn),
    .opcode (id_opcode),
    .rd     (id_rd),
    .rs1    (id_rs1),
    .rs2    (id_rs2),
    .funct3 (id_funct3),
    .funct7 (id_funct7),
    .imm    (id_imm),
    .legal  (legal),
    .is_jal (is_jal)
  );
  assign target   = id_pc + id_imm;
  assign fault    = imem_valid && (!legal || (is_jal && target[1:0] != 2'b00));
  assign redirect = imem_valid && is_jal && !fault;
  // if_pc only advances once a request has actually been issued, so RESET_PC is fetched first
  always_ff @(posedge clk) begin
    if (!resetb) begin
      if_pc      <= RESET_PC;
      id_pc      <= RESET_PC;
      imem_ready <= 1'b0;
      imem_valid <= 1'b0;
      exception  <= 1'b0;
    end else if (!exception) begin
      exception  <= fault;
      imem_ready <= !fault;
      imem_valid <= imem_ready && !redirect && !fault;
      if (!fault) begin
        id_pc <= if_pc;
        if (imem_ready) if_pc <= redirect ? target : if_pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized and directed checks of if_id_stage against a behavioural model
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        exception, imem_ready, imem_valid;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] imem_addr, id_pc, id_insn, id_imm;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;

  if_id_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .resetb(resetb), .exception(exception), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .id_pc(id_pc), .id_insn(id_insn), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) if (imem_ready) imem_rdata <= mem[imem_addr[7:2]];

  int n_cmp = 0;
  int n_err = 0;

  // model state: fetch pointer, decode slot contents, request/exception flags
  logic [31:0] m_pc = 0, m_idpc = 0, m_word = 32'h13;
  bit          m_ready = 0, m_valid = 0, m_exc = 0;

  function automatic bit legal_of(logic [31:0] w);
    return w[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] w);
    int s;
    s = w[31] ? -1 : 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0f, 7'h73: return (s << 12) | {20'h0, w[31:20]};
      7'h23: return (s << 12) | {20'h0, w[31:25], w[11:7]};
      7'h63: return (s << 12) | {20'h0, w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17: return {w[31:12], 12'h000};
      7'h6f: return (s << 20) | {12'h0, w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    logic [31:0] w, tgt, e_insn;
    bit flt, jmp;
    w   = m_valid ? m_word : 32'h13;
    tgt = m_idpc + imm_of(w);
    flt = m_valid && (!legal_of(w) || (w[6:0] == 7'h6f && tgt % 4 != 0));
    jmp = m_valid && w[6:0] == 7'h6f && !flt;
    if (!resetb) begin
      m_pc = 0; m_idpc = 0; m_ready = 0; m_valid = 0; m_exc = 0;
    end else if (!m_exc) begin
      if (flt) begin
        m_exc = 1; m_ready = 0; m_valid = 0;
      end else begin
        m_valid = m_ready && !jmp;
        m_word  = mem[m_pc[7:2]];
        m_idpc  = m_pc;
        if (m_ready) m_pc = jmp ? tgt : m_pc + 4;
        m_ready = 1;
      end
    end
    @(posedge clk);
    #1;
    e_insn = m_valid ? m_word : 32'h13;
    n_cmp++;
    if ({dut.if_pc, imem_addr} !== {m_pc, m_pc}) begin
      n_err++;
      $display("FAIL pc: if_pc=%h imem_addr=%h expected %h", dut.if_pc, imem_addr, m_pc);
    end
    n_cmp++;
    if ({imem_ready, imem_valid, exception} !== {m_ready, m_valid, m_exc}) begin
      n_err++;
      $display("FAIL flags: ready/valid/exc=%b%b%b expected %b%b%b", imem_ready, imem_valid, exception, m_ready, m_valid, m_exc);
    end
    n_cmp++;
    if ({id_pc, id_insn} !== {m_idpc, e_insn}) begin
      n_err++;
      $display("FAIL decode_slot: id_pc=%h id_insn=%h expected %h %h", id_pc, id_insn, m_idpc, e_insn);
    end
    if (legal_of(e_insn)) begin
      n_cmp++;
      if (id_imm !== imm_of(e_insn) || {id_funct7, id_rs2, id_rs1, id_funct3, id_rd, id_opcode} !== e_insn) begin
        n_err++;
        $display("FAIL fields: imm=%h rd=%0d rs1=%0d expected imm=%h insn=%h", id_imm, id_rd, id_rs1, imm_of(e_insn), e_insn);
      end
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    resetb = 0;
    tick();
    resetb = 1;
  endtask

  task automatic test_reset();
    fill_nop();
    resetb = 0;
    repeat (10) tick();
    n_cmp++;
    if ({dut.if_pc, imem_ready, imem_valid, exception} !== {32'h0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: if_pc=%h r/v/e=%b%b%b expected 0 000", dut.if_pc, imem_ready, imem_valid, exception);
    end
  endtask

  task automatic test_nops();
    fill_nop();
    do_reset();
    repeat (20) tick();
    n_cmp++;
    if ({dut.if_pc, id_pc, imem_valid, id_imm} !== {32'd76, 32'd72, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL nop_stream: if_pc=%h id_pc=%h valid=%b imm=%h expected 4c 48 1 0", dut.if_pc, id_pc, imem_valid, id_imm);
    end
  endtask

  task automatic test_jal();
    fill_nop();
    mem[1] = 32'h0080_00EF;
    do_reset();
    repeat (3) tick();
    n_cmp++;
    if ({imem_valid, id_pc, id_rd, id_imm} !== {1'b1, 32'd4, 5'd1, 32'd8}) begin
      n_err++;
      $display("FAIL jal_decode: valid=%b id_pc=%h rd=%0d imm=%h expected 1 4 1 8", imem_valid, id_pc, id_rd, id_imm);
    end
    tick();
    n_cmp++;
    if ({dut.if_pc, imem_valid} !== {32'd12, 1'b0}) begin
      n_err++;
      $display("FAIL jal_redirect: if_pc=%h valid=%b expected c 0", dut.if_pc, imem_valid);
    end
    repeat (4) tick();
  endtask

  task automatic test_neg_imm();
    fill_nop();
    mem[0] = 32'hFFF0_0093;
    do_reset();
    repeat (2) tick();
    n_cmp++;
    if ({id_imm, id_rs1, id_rd} !== {32'hFFFF_FFFF, 5'd0, 5'd1}) begin
      n_err++;
      $display("FAIL neg_imm: imm=%h rs1=%0d rd=%0d expected ffffffff 0 1", id_imm, id_rs1, id_rd);
    end
  endtask

  task automatic test_illegal();
    fill_nop();
    mem[2] = 32'h0000_0000;
    do_reset();
    repeat (5) tick();
    n_cmp++;
    if ({exception, imem_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL illegal_exc: exc=%b ready=%b expected 1 0", exception, imem_ready);
    end
    repeat (110) tick();
    n_cmp++;
    if ({dut.if_pc, exception, imem_ready, imem_valid} !== {32'd12, 3'b100}) begin
      n_err++;
      $display("FAIL illegal_freeze: if_pc=%h e/r/v=%b%b%b expected c 100", dut.if_pc, exception, imem_ready, imem_valid);
    end
  endtask

  task automatic test_misaligned_jal();
    fill_nop();
    mem[1] = 32'h0020_006F;
    do_reset();
    repeat (4) tick();
    n_cmp++;
    if ({exception, dut.if_pc} !== {1'b1, 32'd8}) begin
      n_err++;
      $display("FAIL misaligned_jal: exc=%b if_pc=%h expected 1 8", exception, dut.if_pc);
    end
    repeat (5) tick();
    resetb = 0;
    tick();
    n_cmp++;
    if ({exception, dut.if_pc} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL mid_reset: exc=%b if_pc=%h expected 0 0", exception, dut.if_pc);
    end
    resetb = 1;
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] r, o;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom();
        if ($urandom_range(0, 99) < 12) begin
          o = 32'($signed($urandom_range(0, 32)) - 16) * 4;
          if ($urandom_range(0, 9) == 0) o = o + 2;
          mem[i] = {o[20], o[10:1], o[11], o[19:12], r[11:7], 7'h6f};
        end else if ($urandom_range(0, 99) < 2) mem[i] = r;
        else mem[i] = {r[31:7], ops[$urandom_range(0, 8)]};
      end
      do_reset();
      for (int c = 0; c < 150; c++) begin
        resetb = $urandom_range(0, 99) != 0;
        tick();
      end
      resetb = 1;
    end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_jal();
    test_neg_imm();
    test_illegal();
    test_misaligned_jal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Combined instruction-fetch / instruction-decode front end of the three-stage RV32I pipeline.
- Owns the program counter (if_pc) and issues fetch addresses to a synchronous instruction memory.
- Registers the fetch PC into the decode slot and decodes the returned word into fields and a sign-extended immediate.
- Resolves JAL locally; flags illegal or misaligned-target instructions as a sticky exception.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into if_pc during reset.

Ports:
- clk  in  1  clock
- resetb  in  1  reset: one clock; reset is synchronous and active-low (clk, resetb)
- exception  out  1  sticky exception flag
- imem_ready  out  1  fetch request; memory samples imem_addr this cycle
- imem_rdata  in  32  instruction word, valid one cycle after request
- imem_valid  out  1  imem_rdata holds a live, non-squashed instruction for id_pc
- imem_addr  out  32  fetch byte address, always equal to if_pc
- id_pc  out  32  PC of the instruction in decode
- id_insn  out  32  imem_rdata when imem_valid, else 32'h0000_0013 (NOP)
- id_opcode  out  7  id_insn[6:0]
- id_rd, id_rs1, id_rs2  out  5 each  register fields
- id_funct3  out  3;  id_funct7  out  7
- id_imm  out  32  sign-extended immediate per format

Behaviour:
- Internal register if_pc is visible hierarchically by that name; imem_addr = if_pc.
- Reset (resetb=0 at posedge clk):
  - if_pc <= RESET_PC; id_pc <= RESET_PC.
  - imem_ready <= 0; imem_valid <= 0; exception <= 0.
- Memory contract: a synchronous read. Word address is imem_addr[31:2]; the word appears on imem_rdata the cycle after imem_ready is asserted.
- Normal operation, each posedge with resetb=1 and exception=0:
  - imem_ready <= 1.
  - id_pc <= if_pc.
  - imem_valid <= imem_ready and not squash.
  - if_pc <= redirect ? target : if_pc+4 (32-bit wrap at 32'hFFFF_FFFC -> 0).
- First fetch: if_pc stays at RESET_PC for the first cycle after reset release. The first live decode (imem_valid=1) is the following cycle, with id_pc = RESET_PC.
- Decode is combinational from id_insn.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
  - Immediate formats: I / S / B / U / J, sign bit insn[31]. R-type gives id_imm = 0.
- JAL redirect: when imem_valid and opcode 1101111, target = id_pc + J-imm and redirect=1.
  - The word fetched in that same cycle is squashed: imem_valid = 0 next cycle.
  - Branches and JALR are resolved downstream; this block keeps incrementing for them.
- Exception: set when imem_valid and any of:
  - illegal opcode (includes insn[1:0] != 2'b11);
  - JAL target[1:0] != 0.
- Once exception=1:
  - it holds until reset;
  - if_pc, id_pc freeze; imem_ready=0; imem_valid=0.
  - The faulting instruction's redirect is suppressed.
- Simultaneous redirect and exception: exception wins.
- Reset asserted mid-operation: all state returns to reset values on that edge, regardless of a pending redirect or exception.

Decomposition:
- Shared package rv32i_pkg:
  - opcode localparams;
  - NOP constant 32'h0000_0013;
  - immediate-format enum.
- Sub-module rv32i_decoder: pure combinational. Maps a 32-bit instruction to fields, id_imm, legal and is_jal.

Test Plan:
- Reset: hold resetb=0 for 10 cycles -> if_pc=0, imem_ready=0, imem_valid=0, exception=0 throughout.
- Sequential NOPs (all 32'h0000_0013):
  - after release, if_pc = 0,4,8,...;
  - one cycle later imem_valid=1 with id_pc tracking at 0,4,...;
  - id_imm=0; no exception.
- JAL forward: mem[1]=32'h0080_00EF (jal x1,+8 at PC 4):
  - id_rd=1, id_imm=8;
  - next if_pc=12; fetched word at 8 squashed (imem_valid=0 one cycle).
- Negative immediate: addi x1,x0,-1 (32'hFFF0_0093) -> id_imm=32'hFFFF_FFFF, id_rs1=0, id_rd=1.
- Illegal word 32'h0000_0000 at PC 8:
  - exception=1 the cycle after it is decoded;
  - if_pc frozen for 100+ cycles; imem_ready=0.
- Misaligned JAL target (32'h0020_006F, +2) -> exception=1; no redirect. Re-assert resetb=0 mid-run -> exception=0 and if_pc=RESET_PC on the next edge.
